// File: rtl/i2c_slave_byte_ctrl.sv
// i2c_slave_byte_ctrl: I2C target byte engine (START/STOP detect, 7-bit address match, Rx/Tx bytes, ACK slots)
// Define I2C_SLAVE_GENCALL_EN to also acknowledge the general-call address (7'h00, write).
module i2c_slave_byte_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NBITS = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oe,
  input  logic [6:0] Slave_addr,
  input  logic [7:0] Tx_data,
  output logic       Tx_req,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  input  logic       Rx_ack,
  output logic       Rw,
  output logic       Addr_match,
  output logic       Stop_det,
  output logic       Busy
);
  typedef enum logic [NBITS-1:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE} state_t;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, rw_q, rw_d;
  logic addr_match_q, addr_match_d, stop_det_q, stop_det_d, busy_q, busy_d;
  logic scl_s, sda_s, scl_rise, scl_fall, start, stop, hit;
  logic [7:0] in_byte;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign in_byte  = {shreg_q[6:0], sda_s};
`ifdef I2C_SLAVE_GENCALL_EN
  assign hit = (in_byte[7:1] == Slave_addr) || (in_byte == 8'h00);
`else
  assign hit = in_byte[7:1] == Slave_addr;
`endif

  always_comb begin
    scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], Scl_i};
    sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], Sda_i};
    scl_prev_d   = scl_s;
    sda_prev_d   = sda_s;
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = tx_req_q ? Tx_data : shreg_q;
    rx_data_d    = rx_data_q;
    sda_oe_d     = sda_oe_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;
    addr_match_d = 1'b0;
    stop_det_d   = 1'b0;
    if (stop) begin
      state_d    = IDLE;
      cnt_d      = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = busy_q;
    end else if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d = in_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d        = '0;
            state_d      = hit ? ADDR_ACK : IGNORE;
            rw_d         = hit ? in_byte[0] : rw_q;
            addr_match_d = hit;
            busy_d       = hit;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            sda_oe_d = 1'b1;
            cnt_d    = 4'd1;
            tx_req_d = rw_q;
          end else if (rw_q) begin
            // first Tx bit goes out on the same falling edge that ends the ACK slot
            state_d  = TX;
            sda_oe_d = ~shreg_q[7];
            shreg_d  = {shreg_q[6:0], 1'b0};
            cnt_d    = 4'd1;
          end else begin
            state_d  = RX;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end
        RX: if (scl_rise) begin
          shreg_d = in_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d      = '0;
            rx_data_d  = in_byte;
            rx_valid_d = 1'b1;
            state_d    = RX_ACK;
          end
        end
        RX_ACK: if (scl_fall) begin
          sda_oe_d = cnt_q == 4'd0 ? ~Rx_ack : 1'b0;
          cnt_d    = cnt_q == 4'd0 ? 4'd1 : 4'd0;
          state_d  = cnt_q == 4'd0 ? RX_ACK : RX;
        end
        TX: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = TX_ACK;
          end else begin
            sda_oe_d = ~shreg_q[7];
            shreg_d  = {shreg_q[6:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end
        end
        TX_ACK: if (scl_rise) begin
          state_d  = sda_s ? IGNORE : TX;
          tx_req_d = ~sda_s;
          cnt_d    = '0;
        end
        IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      rw_q         <= 1'b0;
      addr_match_q <= 1'b0;
      stop_det_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      sda_oe_q     <= sda_oe_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      rw_q         <= rw_d;
      addr_match_q <= addr_match_d;
      stop_det_q   <= stop_det_d;
      busy_q       <= busy_d;
    end
  end

  assign Sda_oe     = sda_oe_q;
  assign Tx_req     = tx_req_q;
  assign Rx_data    = rx_data_q;
  assign Rx_valid   = rx_valid_q;
  assign Rw         = rw_q;
  assign Addr_match = addr_match_q;
  assign Stop_det   = stop_det_q;
  assign Busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// tb_i2c_slave_byte_ctrl: bit-banged I2C master with transaction-level expectations and a scoreboard monitor
module tb_i2c_slave_byte_ctrl;
  localparam int Q = 4;
  localparam int H = 8;
  localparam logic [6:0] OWN = 7'h50;
`ifdef I2C_SLAVE_GENCALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, scl_m = 1'b1, sda_m = 1'b1, sda_bus;
  logic sda_oe, tx_req, rx_valid, rx_ack = 1'b0, rw, addr_match, stop_det, busy;
  logic [6:0] slave_addr = OWN;
  logic [7:0] tx_data = 8'h00, rx_data;
  int checks = 0, errors = 0, txreq_seen = 0, txreq_exp = 0;
  bit busy_m = 1'b0;
  logic [7:0] txd [8];
  bit rxa [8];
  logic [7:0] exp_rx[$], exp_rd[$], rd_obs[$];
  bit exp_am[$], exp_ack[$], ack_obs[$], exp_stop[$];

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_byte_ctrl dut (
    .Clk(clk), .Rst(rst), .Scl_i(scl_m), .Sda_i(sda_bus), .Sda_oe(sda_oe),
    .Slave_addr(slave_addr), .Tx_data(tx_data), .Tx_req(tx_req), .Rx_data(rx_data),
    .Rx_valid(rx_valid), .Rx_ack(rx_ack), .Rw(rw), .Addr_match(addr_match),
    .Stop_det(stop_det), .Busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected pulse 1, required 0", nm);
  endtask

  always @(negedge clk) if (!rst) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) unexp("rx_valid");
      else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (addr_match) begin
      if (exp_am.size() == 0) unexp("addr_match");
      else chk("rw", rw, exp_am.pop_front());
    end
    if (stop_det) begin
      if (exp_stop.size() == 0) unexp("stop_det");
      else chk("stop_det", stop_det, exp_stop.pop_front());
    end
    if (tx_req) txreq_seen++;
    if (ack_obs.size() > 0 && exp_ack.size() > 0) chk("ack_slot", ack_obs.pop_front(), exp_ack.pop_front());
    if (rd_obs.size() > 0 && exp_rd.size() > 0) chk("read_byte", rd_obs.pop_front(), exp_rd.pop_front());
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b; hold(Q); scl_m = 1'b1; hold(H); scl_m = 1'b0; hold(Q);
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; hold(Q); scl_m = 1'b1; hold(H / 2); b = sda_bus; hold(H / 2); scl_m = 1'b0; hold(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    ack_obs.push_back(!a);
  endtask

  task automatic rd_byte(input logic nack);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) rd_bit(d[i]);
    rd_obs.push_back(d);
    wr_bit(nack);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; hold(Q); scl_m = 1'b1; hold(Q); sda_m = 1'b0; hold(Q); scl_m = 1'b0; hold(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; hold(Q); scl_m = 1'b1; hold(Q); sda_m = 1'b1; hold(Q);
  endtask

  // One transaction: START/Sr, address, n data bytes, optional STOP; expectations come from the protocol rules
  task automatic xfer(input logic [6:0] a, input logic r, input int n, input bit end_stop);
    bit m;
    m = (a == OWN) || (GC && a == 7'h00 && !r);
    if (m && r) begin
      tx_data = txd[0];
      txreq_exp += n;
    end
    bus_start();
    chk("busy_at_start", busy, busy_m);
    exp_ack.push_back(m);
    if (m) exp_am.push_back(r);
    wr_byte({a, r});
    busy_m = m;
    chk("busy_after_addr", busy, busy_m);
    for (int i = 0; i < n; i++) begin
      if (r) begin
        exp_rd.push_back(m ? txd[i] : 8'hFF);
        if (i + 1 < n) tx_data = txd[i + 1];
        rd_byte(i == n - 1);
      end else begin
        rx_ack = rxa[i];
        exp_ack.push_back(m && !rxa[i]);
        if (m) exp_rx.push_back(txd[i]);
        wr_byte(txd[i]);
      end
    end
    if (end_stop) begin
      if (busy_m) exp_stop.push_back(1'b1);
      bus_stop();
      busy_m = 1'b0;
      chk("busy_after_stop", busy, 0);
    end
  endtask

  initial begin
    logic [7:0] ab;
    int sel, n;
    logic [6:0] a;
    #2 rst = 1'b1;
    #2;
    chk("rst_outputs", {sda_oe, tx_req, rx_valid, rw, addr_match, stop_det, busy}, 0);
    chk("rst_rx_data", rx_data, 0);
    hold(5);
    rst = 1'b0;
    hold(5);
    txd[0] = 8'h3C; rxa[0] = 1'b0;
    xfer(OWN, 1'b0, 1, 1'b1);
    chk("rx_data_hold", rx_data, 8'h3C);
    xfer(7'h51, 1'b0, 0, 1'b1);
    txd[0] = 8'h96; txd[1] = 8'h0F;
    xfer(OWN, 1'b1, 2, 1'b1);
    txd[0] = 8'h11; rxa[0] = 1'b0;
    xfer(OWN, 1'b0, 1, 1'b0);
    txd[0] = 8'hC3;
    xfer(OWN, 1'b1, 1, 1'b1);
    txd[0] = 8'h55; rxa[0] = 1'b1;
    xfer(OWN, 1'b0, 1, 1'b1);
    // reset while the target is pulling SDA low for the address ACK
    ab = {OWN, 1'b0};
    bus_start();
    exp_am.push_back(1'b0);
    for (int i = 7; i >= 0; i--) wr_bit(ab[i]);
    sda_m = 1'b1; hold(Q); scl_m = 1'b1; hold(H / 2);
    chk("ack_driven", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("rst_sda_release", sda_oe, 0);
    chk("rst_busy", busy, 0);
    hold(4);
    rst = 1'b0;
    busy_m = 1'b0;
    hold(4);
    txd[0] = 8'h5A; rxa[0] = 1'b0;
    xfer(7'h00, 1'b0, 1, 1'b1);
    for (int t = 0; t < 25; t++) begin
      sel = $urandom_range(0, 3);
      a = sel == 0 ? OWN : sel == 1 ? (OWN ^ 7'h01) : sel == 2 ? 7'h00 : 7'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        txd[i] = 8'($urandom);
        rxa[i] = $urandom_range(0, 3) == 0;
      end
      xfer(a, 1'($urandom), n, (t == 24) || ($urandom_range(0, 2) != 0));
    end
    hold(20);
    chk("txreq_count", txreq_seen, txreq_exp);
    chk("rx_pending", exp_rx.size(), 0);
    chk("addr_match_pending", exp_am.size(), 0);
    chk("stop_pending", exp_stop.size(), 0);
    chk("ack_pending", exp_ack.size(), 0);
    chk("ack_unmatched", ack_obs.size(), 0);
    chk("read_pending", exp_rd.size(), 0);
    chk("read_unmatched", rd_obs.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
